fifo_push_arbiter: RTL and testbench

- Round-robin arbiter that shares the single push port of a FIFO controller between num_req requesters.
- Grants one requester at a time for a bounded burst and drives the FIFO's active-low push_req_n.
- Throttles new grants on FIFO full / almost-full status.
- Sits in front of the push side of the FIFO controllers, single clock domain.

---
 rtl/fifo_push_arbiter.sv | 76 +++++++
 tb/tb_fifo_push_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin arbiter sharing one FIFO push port among num_req requesters,
// with bounded bursts per grant and full/almost-full throttling of new grants.
module fifo_push_arbiter #(
    parameter int num_req     = 4,
    parameter int max_burst   = 4,
    parameter bit af_throttle = 1'b1,
    parameter int idx_width   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [num_req-1:0]   req,
    input  logic                 fifo_full,
    input  logic                 fifo_af,
    output logic                 push_req_n,
    output logic [num_req-1:0]   grant,
    output logic [idx_width-1:0] grant_idx,
    output logic [num_req-1:0]   word_ack,
    output logic                 busy
);
    localparam int cw = max_burst > 1 ? $clog2(max_burst) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state_q, state_d;
    logic [idx_width-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d;
    logic [idx_width-1:0] owner_nxt, start, sel;
    logic [cw-1:0]        cnt_q, cnt_d;
    logic                 accept, release_w, can_grant;

    assign busy      = state_q == GRANT;
    assign can_grant = |req & ~fifo_full & ~(af_throttle & fifo_af);
    assign accept    = busy & req[owner_q] & ~fifo_full;
    assign release_w = busy & (~req[owner_q] | (accept & cnt_q == cw'(max_burst - 1)));
    assign owner_nxt = idx_width'((int'(owner_q) + 1) % num_req);
    assign start     = release_w ? owner_nxt : rr_ptr_q;

    // Walk backwards so the requester closest to start wins.
    always_comb begin
        sel = start;
        for (int k = num_req - 1; k >= 0; k--)
            if (req[(int'(start) + k) % num_req]) sel = idx_width'((int'(start) + k) % num_req);
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = release_w ? owner_nxt : rr_ptr_q;
        cnt_d    = cnt_q;
        if (state_q == IDLE || release_w) begin
            state_d = can_grant ? GRANT : IDLE;
            owner_d = can_grant ? sel : owner_q;
            cnt_d   = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant      = busy ? num_req'(1) << owner_q : '0;
    assign grant_idx  = owner_q;
    assign word_ack   = grant & {num_req{accept}};
    assign push_req_n = ~accept;
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed checks of two arbiter configurations sharing one stimulus:
// a (max_burst=4, af_throttle=1) and b (max_burst=2, af_throttle=0).
module tb_fifo_push_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       fifo_full, fifo_af;
    logic       a_pn, b_pn, a_busy, b_busy;
    logic [3:0] a_grant, b_grant, a_ack, b_ack;
    logic [1:0] a_idx, b_idx;
    int         n_chk = 0;
    int         n_pass = 0;
    int         acks;

    always #5 clk = ~clk;

    fifo_push_arbiter #(.num_req(4), .max_burst(4), .af_throttle(1'b1), .idx_width(2)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req), .fifo_full(fifo_full), .fifo_af(fifo_af),
        .push_req_n(a_pn), .grant(a_grant), .grant_idx(a_idx), .word_ack(a_ack), .busy(a_busy)
    );

    fifo_push_arbiter #(.num_req(4), .max_burst(2), .af_throttle(1'b0), .idx_width(2)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req), .fifo_full(fifo_full), .fifo_af(fifo_af),
        .push_req_n(b_pn), .grant(b_grant), .grant_idx(b_idx), .word_ack(b_ack), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0; req = '0; fifo_full = 1'b0; fifo_af = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; fifo_full = 1'b0; fifo_af = 1'b0;
        #1;
        chk("rst_grant", a_grant, 4'b0000);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_pn", a_pn, 1'b1);
        chk("rst_idx", a_idx, 2'd0);
        chk("rst_ack", a_ack, 4'b0000);
        tick();
        rst_n = 1'b1;

        // single requester: 4-word burst then immediate regrant
        tick(); req = 4'b0001; #1;
        chk("t1_idle_grant", a_grant, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            tick(); #1;
            chk("t1_grant", a_grant, 4'b0001);
            chk("t1_pn", a_pn, 1'b0);
            chk("t1_ack", a_ack, 4'b0001);
        end
        tick(); req = 4'b0000; #1;
        chk("t1_drop_pn", a_pn, 1'b1);
        chk("t1_drop_ack", a_ack, 4'b0000);
        tick(); #1;
        chk("t1_idle", a_grant, 4'b0000);
        chk("t1_idle_busy", a_busy, 1'b0);

        // all requesting, max_burst=2: owners 0,0,1,1,2,2,3,3,0,0
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            tick(); #1;
            chk("t2_grant", b_grant, 4'b0001 << ((k / 2) % 4));
            chk("t2_ack", b_ack, 4'b0001 << ((k / 2) % 4));
            chk("t2_pn", b_pn, 1'b0);
        end

        // owner 2 stalled by fifo_full mid-burst, then rotates to 3
        do_reset();
        req = 4'b1100; acks = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            fifo_full = k >= 2 && k <= 4;
            #1;
            chk("t3_grant", a_grant, 4'b0100);
            chk("t3_pn", a_pn, fifo_full);
            if (a_ack == 4'b0100) acks++;
        end
        chk("t3_acks", acks, 4);
        tick(); #1;
        chk("t3_rotate", a_grant, 4'b1000);
        tick(); req = 4'b0000;
        tick(); #1;
        chk("t3_idle", a_grant, 4'b0000);
        chk("t3_hold_idx", a_idx, 2'd3);

        // almost-full throttling of new grants
        do_reset();
        fifo_af = 1'b1; req = 4'b0010;
        tick(); #1;
        chk("t4_a_grant", a_grant, 4'b0000);
        chk("t4_a_busy", a_busy, 1'b0);
        chk("t4_b_grant", b_grant, 4'b0010);
        chk("t4_b_busy", b_busy, 1'b1);
        tick(); #1;
        chk("t4_a_hold", a_grant, 4'b0000);
        chk("t4_a_pn", a_pn, 1'b1);

        // owner 1 drops after one word; search restarts at 2 so 3 beats 0
        do_reset();
        req = 4'b1010;
        tick(); #1;
        chk("t5_grant1", a_grant, 4'b0010);
        chk("t5_ack1", a_ack, 4'b0010);
        tick(); req = 4'b1001; #1;
        chk("t5_drop_pn", a_pn, 1'b1);
        chk("t5_drop_ack", a_ack, 4'b0000);
        tick(); #1;
        chk("t5_grant3", a_grant, 4'b1000);
        chk("t5_idx3", a_idx, 2'd3);

        // async reset mid-burst, then rr_ptr restarts at 0
        do_reset();
        req = 4'b1000;
        tick(); #1;
        chk("t6_grant3", a_grant, 4'b1000);
        tick(); #1;
        chk("t6_ack3", a_ack, 4'b1000);
        #2 rst_n = 1'b0; #1;
        chk("t6_rst_grant", a_grant, 4'b0000);
        chk("t6_rst_pn", a_pn, 1'b1);
        chk("t6_rst_ack", a_ack, 4'b0000);
        chk("t6_rst_idx", a_idx, 2'd0);
        tick(); rst_n = 1'b1; req = 4'b1001; #1;
        chk("t6_idle", a_grant, 4'b0000);
        tick(); #1;
        chk("t6_grant0", a_grant, 4'b0001);
        chk("t6_idx0", a_idx, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
